// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg: register map, STATUS layout and FSM encodings shared by uart_txq.
// The S_PARITY encoding exists only when UART_TX_PARITY_EN is defined.
package uart_txq_pkg;

    localparam int ADR_WIDTH = 32;
    localparam int DAT_WIDTH = 32;

    localparam int   REG_SEL_BIT = 3;
    localparam logic REG_DATA    = 1'b0;
    localparam logic REG_STATUS  = 1'b1;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_LVL_LSB = 8;
    localparam int ST_LVL_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } tx_state_e;

endpackage

// File: rtl/uart_txq_fifo.sv
// uart_fifo: synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Pointers wrap modulo DEPTH (power of two); the level counter carries one extra bit.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Fullness is taken before any coincident pop, so a push while full is dropped.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_txq.sv
// uart_txq: Wishbone-slave UART transmitter with TX FIFO, baud-tick timing and STATUS register.
// Define UART_TX_PARITY_EN to append a parity bit (polarity PARITY_ODD) to every frame.
module uart_txq
    import uart_txq_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADR_WIDTH-1:0] uart_adr_i,
    input  logic [DAT_WIDTH-1:0] uart_dat_i,
    output logic [DAT_WIDTH-1:0] uart_dat_o,
    input  logic                 uart_we_i,
    input  logic                 uart_stb_i,
    output logic                 uart_ack_o,
    output logic                 uart_err_o,
    output logic                 uart_tx
);
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W  = $clog2(DIV);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BITN_W = 3;

    // ---------------- FIFO ----------------
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [LVL_W-1:0]     fifo_level;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (uart_dat_i[DATA_BITS-1:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // ---------------- Bus slave ----------------
    tx_state_e            state_q, state_d;
    logic                 ack_q, err_q;
    logic [DAT_WIDTH-1:0] dat_q, status;
    logic                 req_new, sel_data, wr_ok, rd_ok;

    always_comb begin
        status                            = '0;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_FULL]                   = fifo_full;
        status[ST_BUSY]                   = (state_q != S_IDLE);
        status[ST_LVL_LSB +: ST_LVL_W]    = ST_LVL_W'(fifo_level);
    end

    // A request is new only on its first strobed cycle; the response cycle blocks re-entry.
    assign req_new   = uart_stb_i && !ack_q && !err_q;
    assign sel_data  = (uart_adr_i[REG_SEL_BIT] == REG_DATA);
    assign wr_ok     = req_new && uart_we_i && sel_data && !fifo_full;
    assign rd_ok     = req_new && !uart_we_i && (uart_adr_i[REG_SEL_BIT] == REG_STATUS);
    assign fifo_push = wr_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= wr_ok || rd_ok;
            err_q <= req_new && !(wr_ok || rd_ok);
            if (rd_ok)        dat_q <= status;
            else if (req_new) dat_q <= '0;
        end
    end

    assign uart_ack_o = ack_q && uart_stb_i;
    assign uart_err_o = err_q && uart_stb_i;
    assign uart_dat_o = dat_q;

    // ---------------- Baud counter, FSM, shifter ----------------
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BITN_W-1:0]    bitn_q, bitn_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign baud_tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        bitn_d   = bitn_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != S_IDLE) cnt_d = baud_tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    bitn_d  = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bitn_q == BITN_W'(DATA_BITS - 1)) begin
                        bitn_d  = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bitn_d = bitn_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    bitn_d  = '0;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    if (bitn_q == BITN_W'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = S_START;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end else begin
                        bitn_d = bitn_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fifo_pop) begin
            shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d   = (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
        end

        if (state_d != state_q) cnt_d = '0;

        // Line level follows the next state so uart_tx stays a plain register output.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign uart_tx = tx_q;

    logic unused_ok;
`ifdef UART_TX_PARITY_EN
    assign unused_ok = ^{uart_adr_i, uart_dat_i, fifo_level};
`else
    assign unused_ok = ^{uart_adr_i, uart_dat_i, fifo_level, 1'(PARITY_ODD)};
`endif

endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: randomized bus traffic against a time-scheduled frame model of uart_txq.
// Build with UART_TX_PARITY_EN to exercise the 7E/O2 parity configuration.
`timescale 1ns/1ps
module tb_uart_txq;
    import uart_txq_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 125_000;
`ifdef UART_TX_PARITY_EN
    localparam int DATA_BITS = 7, STOP_BITS = 2, PARITY_ODD = 1, PAR = 1;
`else
    localparam int DATA_BITS = 8, STOP_BITS = 1, PARITY_ODD = 0, PAR = 0;
`endif
    localparam int FIFO_DEPTH = 4;
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int FRAME = 1 + DATA_BITS + PAR + STOP_BITS;
    localparam int FLEN  = FRAME * DIV;
    localparam int MAXF  = 1024;

    logic                 clk, rst;
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] wdat, rdat;
    logic                 we, stb, ack, err, tx;

    uart_txq #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
        .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .uart_adr_i(adr), .uart_dat_i(wdat), .uart_dat_o(rdat),
        .uart_we_i(we), .uart_stb_i(stb), .uart_ack_o(ack), .uart_err_o(err), .uart_tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Each accepted byte: edge it was pushed, edge its start bit begins, its value.
    int         f_push  [MAXF];
    int         f_start [MAXF];
    logic [7:0] f_data  [MAXF];
    int         nf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Posedge k happens at time 10k+5; called at negedges only.
    function automatic int last_edge();
        return int'(($time - 64'd5) / 64'd10);
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        logic [7:0] m;
        m = d & 8'((1 << DATA_BITS) - 1);
        if (b == 0) return 1'b0;
        if (b <= DATA_BITS) return m[b-1];
        if (PAR == 1 && b == DATA_BITS + 1) return (^m) ^ 1'(PARITY_ODD);
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int k);
        for (int i = 0; i < nf; i++)
            if (k >= f_start[i] && k < f_start[i] + FLEN)
                return frame_bit(f_data[i], (k - f_start[i]) / DIV);
        return 1'b1;
    endfunction

    // Bytes waiting in the FIFO just before edge e.
    function automatic int level_at(input int e);
        int n = 0;
        for (int i = 0; i < nf; i++)
            if (f_push[i] < e && f_start[i] >= e) n++;
        return n;
    endfunction

    function automatic bit busy_at(input int e);
        for (int i = 0; i < nf; i++)
            if (f_start[i] < e && e <= f_start[i] + FLEN) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (rst) check("tx_in_reset", {31'b0, tx}, 32'd1);
        else     check("tx_line", {31'b0, tx}, {31'b0, exp_tx(last_edge())});
    end

    task automatic bus(input bit w, input bit to_status, input logic [7:0] d, input bit hold);
        int e, lvl, st;
        bit ok;
        logic [31:0] exp_st;
        @(negedge clk);
        e   = last_edge() + 1;
        lvl = level_at(e);
        ok  = w ? (!to_status && lvl < FIFO_DEPTH) : to_status;
        exp_st = (32'(lvl & 8'hFF) << 8) | (32'(busy_at(e)) << 2)
               | (32'(lvl == FIFO_DEPTH) << 1) | 32'(lvl == 0);
        if (w && ok) begin
            st = e + 1;
            if (nf > 0 && f_start[nf-1] + FLEN > st) st = f_start[nf-1] + FLEN;
            f_push[nf] = e; f_start[nf] = st; f_data[nf] = d; nf++;
        end
        adr  = (32'($urandom) & 32'hFFFF_FFF7) | (to_status ? 32'h8 : 32'h0);
        wdat = (32'($urandom) & 32'hFFFF_FF00) | 32'(d);
        we   = w;
        stb  = 1'b1;
        @(negedge clk);
        check("ack", {31'b0, ack}, {31'b0, ok});
        check("err", {31'b0, err}, {31'b0, !ok});
        if (!w && to_status) check("status", rdat, exp_st);
        if (hold) begin
            @(negedge clk);
            check("ack_one_cycle", {30'b0, ack, err}, 32'd0);
        end
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic drain();
        int lim;
        lim = (nf > 0) ? f_start[nf-1] + FLEN + 2 : 0;
        while (last_edge() < lim) @(negedge clk);
    endtask

    initial begin
        int s, r, gap;
        rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_tx",  {31'b0, tx}, 32'd1);
        rst = 1'b0;
        bus(1'b0, 1'b1, 8'h00, 1'b0);            // STATUS == 0x01

        bus(1'b1, 1'b0, 8'h55, 1'b1);            // single frame, ack held check
        drain();
        bus(1'b1, 1'b0, 8'h03, 1'b0);
        drain();

        bus(1'b1, 1'b0, 8'h41, 1'b0);
        bus(1'b1, 1'b0, 8'h42, 1'b0);
        bus(1'b1, 1'b0, 8'h43, 1'b0);
        repeat (12) begin
            repeat (20) @(negedge clk);
            bus(1'b0, 1'b1, 8'h00, 1'b0);
        end
        drain();

        for (int i = 0; i < 6; i++) bus(1'b1, 1'b0, 8'($urandom), 1'b0);
        bus(1'b0, 1'b1, 8'h00, 1'b0);            // full flag
        bus(1'b1, 1'b1, 8'hA5, 1'b0);            // write STATUS -> err
        bus(1'b0, 1'b0, 8'h00, 1'b0);            // read DATA -> err
        bus(1'b0, 1'b1, 8'h00, 1'b0);
        drain();

        for (int i = 0; i < 80; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * FLEN) : $urandom_range(0, 5);
            repeat (gap) @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 6)       bus(1'b1, 1'b0, 8'($urandom), 1'b0);
            else if (r < 8)  bus(1'b0, 1'b1, 8'h00, 1'b0);
            else if (r == 8) bus(1'b1, 1'b1, 8'($urandom), 1'b0);
            else             bus(1'b0, 1'b0, 8'h00, 1'b0);
        end
        drain();

        // Reset in the middle of the first data bit of an all-zero byte.
        bus(1'b1, 1'b0, 8'h00, 1'b0);
        s = f_start[nf-1];
        while (last_edge() < s + DIV + 2) @(negedge clk);
        #2 rst = 1'b1;
        nf = 0;
        #1 check("rst_async_tx", {31'b0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus(1'b0, 1'b1, 8'h00, 1'b0);
        repeat (2 * FLEN) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
